// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner: synchronises and debounces the raw button,
// latches one walk request per debounced press, and holds off re-requests after an acknowledge.

module ped_request_conditioner_chk (
    input logic clk,
    input logic rst_n,
    input logic req,
    input logic req_pulse,
    input logic lockout
);

    // A new-request strobe is only ever issued together with the request level
    a_pulse_with_req: assert property (@(posedge clk) disable iff (!rst_n)
        req_pulse |-> req);

    // The request is withdrawn for the whole lockout window
    a_lockout_no_req: assert property (@(posedge clk) disable iff (!rst_n)
        lockout |-> !req);

    // Every rise of the request level is announced by the strobe
    a_rise_has_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(req) |-> req_pulse);

endmodule

module ped_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    input  logic ack,
    output logic req,
    output logic req_pulse,
    output logic btn_clean,
    output logic lockout
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    // One extra value keeps the counter at least one bit wide when LOCKOUT_CYCLES is 1
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [LK_W-1:0] LK_ONE  = LK_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    logic            s1_r;
    logic            btn_sync_r;
    logic            btn_clean_r;
    logic            btn_clean_d_r;
    logic [DB_W-1:0] db_cnt_r;
    state_t          state_r;
    logic            req_r;
    logic            req_pulse_r;
    logic            lockout_r;
    logic [LK_W-1:0] lk_cnt_r;
    logic            press_s;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r       <= 1'b0;
            btn_sync_r <= 1'b0;
        end else if (!ena) begin
            s1_r       <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            s1_r       <= btn_raw;
            btn_sync_r <= s1_r;
        end
    end

    // Debounce: the clean level follows only after a full run of stable samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_clean_r   <= 1'b0;
            btn_clean_d_r <= 1'b0;
            db_cnt_r      <= '0;
        end else if (!ena) begin
            btn_clean_r   <= 1'b0;
            btn_clean_d_r <= 1'b0;
            db_cnt_r      <= '0;
        end else begin
            btn_clean_d_r <= btn_clean_r;
            if (btn_sync_r == btn_clean_r) begin
                db_cnt_r <= '0;
            end else if (db_cnt_r == DB_MAX) begin
                btn_clean_r <= btn_sync_r;
                db_cnt_r    <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + DB_ONE;
            end
        end
    end

    assign press_s = btn_clean_r & ~btn_clean_d_r;

    // Request handshake FSM; a press seen outside IDLE is dropped rather than queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            req_pulse_r <= 1'b0;
            lockout_r   <= 1'b0;
            lk_cnt_r    <= '0;
        end else if (!ena) begin
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            req_pulse_r <= 1'b0;
            lockout_r   <= 1'b0;
            lk_cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    lockout_r <= 1'b0;
                    if (press_s) begin
                        state_r     <= ST_PENDING;
                        req_r       <= 1'b1;
                        req_pulse_r <= 1'b1;
                    end else begin
                        req_r       <= 1'b0;
                        req_pulse_r <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    req_pulse_r <= 1'b0;
                    if (ack) begin
                        state_r   <= ST_LOCKOUT;
                        req_r     <= 1'b0;
                        lockout_r <= 1'b1;
                        lk_cnt_r  <= LK_LOAD;
                    end else begin
                        req_r     <= 1'b1;
                        lockout_r <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    req_r       <= 1'b0;
                    req_pulse_r <= 1'b0;
                    if (lk_cnt_r == '0) begin
                        state_r   <= ST_IDLE;
                        lockout_r <= 1'b0;
                    end else begin
                        lockout_r <= 1'b1;
                        lk_cnt_r  <= lk_cnt_r - LK_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_r       <= 1'b0;
                    req_pulse_r <= 1'b0;
                    lockout_r   <= 1'b0;
                    lk_cnt_r    <= '0;
                end
            endcase
        end
    end

    assign req       = req_r;
    assign req_pulse = req_pulse_r;
    assign btn_clean = btn_clean_r;
    assign lockout   = lockout_r;

    ped_request_conditioner_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_r),
        .req_pulse (req_pulse_r),
        .lockout   (lockout_r)
    );

endmodule
